// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The master is the fetch/decode pair; the slave is the queue itself.
interface fetch_queue_if #(
  parameter int PAYLOAD_W = 148
);
  logic                 in_valid;
  logic                 in_two;
  logic [PAYLOAD_W-1:0] in_data0;
  logic [PAYLOAD_W-1:0] in_data1;
  logic                 in_ready;
  logic                 out_valid0;
  logic                 out_valid1;
  logic [PAYLOAD_W-1:0] out_data0;
  logic [PAYLOAD_W-1:0] out_data1;
  logic                 deq0;
  logic                 deq1;

  modport master (
    output in_valid, in_two, in_data0, in_data1, deq0, deq1,
    input  in_ready, out_valid0, out_valid1, out_data0, out_data1
  );

  modport slave (
    input  in_valid, in_two, in_data0, in_data1, deq0, deq1,
    output in_ready, out_valid0, out_valid1, out_data0, out_data1
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular-pointer instruction queue between fetch and the dual decoders.
// Accepts 0/1/2 in-order entries per cycle, presents the two oldest entries,
// and retires 0/1/2 per cycle in strict order. Occupancy is tracked in a
// separate counter so full/empty never depend on pointer comparison.
module fetch_queue #(
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 148,
  parameter int AF_LEVEL  = DEPTH - 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         stall,
  fetch_queue_if.slave                 fq,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [PW-1:0]        head_plus1;
  logic [PW-1:0]        tail_plus1;
  logic                 enq_fire;
  logic [1:0]           enq_n;
  logic [1:0]           deq_n;

  // Room for a full two-lane group is required even for a single-lane group,
  // so fetch never has to know the group size ahead of time.
  assign fq.in_ready   = (count <= CW'(DEPTH - 2));
  assign almost_full   = (32'(count) >= AF_LEVEL);
  assign fq.out_valid0 = (count >= CW'(1));
  assign fq.out_valid1 = (count >= CW'(2));

  // Pointers wrap for free because DEPTH is a power of two.
  assign head_plus1 = head + PW'(1);
  assign tail_plus1 = tail + PW'(1);

  assign fq.out_data0 = fq.out_valid0 ? mem[head]       : '0;
  assign fq.out_data1 = fq.out_valid1 ? mem[head_plus1] : '0;

  // Enqueue is suppressed by reset, flush and stall; an offered group with
  // in_ready low is simply dropped.
  assign enq_fire = rstn & fq.in_valid & fq.in_ready & ~stall & ~flush;
  assign enq_n    = enq_fire ? (fq.in_two ? 2'd2 : 2'd1) : 2'd0;

  // Dequeue count: lane 1 only retires together with lane 0 (strict order).
  always_comb begin
    deq_n = 2'd0;
    if (!stall) begin
      if (fq.deq0 && fq.deq1 && fq.out_valid1) begin
        deq_n = 2'd2;
      end else if (fq.deq0 && fq.out_valid0) begin
        deq_n = 2'd1;
      end
    end
  end

  // Payload storage write: lane 0 at tail, lane 1 at tail+1 (wrapped).
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail] <= fq.in_data0;
      if (fq.in_two) begin
        mem[tail_plus1] <= fq.in_data1;
      end
    end
  end

  // Pointer and occupancy update: reset, then flush, then stall, then normal.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (!stall) begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised, circular-pointer instruction queue between the I-cache fetch stage and the dual decoders, replacing the fixed 16-entry shift-register fetch buffer. Accepts 0, 1 or 2 in-order instruction payloads per cycle from fetch. Presents the two oldest entries to decode, which may independently take 0, 1 or 2 per cycle. Payload is opaque (ir/pc/npc/pre/plv/excp_arg packed by the caller), so width and depth are free parameters.

## Interface
- DEPTH, 16, number of entries; power of two, ≥4
- PAYLOAD_W, 148, bits per instruction entry
- AF_LEVEL, DEPTH-4, occupancy at or above which almost_full asserts
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- flush  in  1  synchronous queue clear (branch mispredict / exception)
- stall  in  1  global freeze; no enqueue, no dequeue, state held
- in_valid  in  1  fetch group valid this cycle
- in_two  in  1  1 = both lanes valid, 0 = lane 0 only
- in_data0  in  PAYLOAD_W  older instruction of the group
- in_data1  in  PAYLOAD_W  younger instruction; ignored when in_two=0
- in_ready  out  1  free entries ≥ 2
- out_valid0, out_valid1  out  1 each  oldest / second-oldest entry present
- out_data0, out_data1  out  PAYLOAD_W each  oldest / second-oldest payload; 0 when corresponding valid is 0
- deq0, deq1  in  1 each  decoder consumes lane 0 / lane 1
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count ≥ AF_LEVEL

## Operation
- Storage: DEPTH × PAYLOAD_W array. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count register is kept separately; full/empty are derived from count, not from pointer compare.
- Enqueue fires when in_valid & in_ready & !stall & !flush. Writes in_data0 at tail. If in_two, also writes in_data1 at tail+1. Tail advances by 1 or 2.
- Fetch must not present in_valid while in_ready=0. Such a group is dropped and state is unchanged.
- Dequeue count n:
  - n = 2 when deq0 & deq1 & out_valid1.
  - n = 1 when deq0 & out_valid0 and the two-entry condition does not hold.
  - n = 0 otherwise.
  - deq1 without deq0 is ignored; order is strict.
  - Head advances by n and count decreases by n.
- count_next = count + enq_n − deq_n. Enqueue and dequeue in the same cycle are both applied.
- in_ready is computed from current count only (DEPTH − count ≥ 2). Same-cycle dequeue does not raise it.
- Outputs read combinationally at head and head+1 (wrapped):
  - out_valid0 = count ≥ 1; out_valid1 = count ≥ 2.
  - No bypass: an entry written this cycle becomes visible next cycle.
- Priority, highest first:
  - rstn=0: full clear.
  - flush: head = tail = count = 0, all same-cycle enqueue and dequeue discarded. Array contents need not be cleared.
  - stall: everything held, deq ignored.
  - normal operation.

## Timing
- Reset values: count=0, in_ready=1, out_valid0=out_valid1=0, out_data0=out_data1=0, almost_full=0 (when AF_LEVEL>0).
- Latency: enqueue at edge N → entry visible on out_* after edge N (same cycle as the following clk high).
- Dequeue takes effect at the edge where deq is sampled. The next entries are on out_* immediately after that edge.
- Full boundary: count = DEPTH−1 → in_ready=0, even though one slot is free. A single-lane group also waits.
- Empty boundary: count=0 → deq0/deq1 have no effect; count never underflows.
- Wrap: a two-lane enqueue at tail=DEPTH−1 writes entries DEPTH−1 and 0. Head wrap is handled identically.
- flush during a cycle with in_valid=1: the group is lost. Fetch re-issues after redirect.
- Reset mid-operation: queue empty the next cycle regardless of flush/stall.

## Test plan
- Reset, then 3 idle cycles → count=0, in_ready=1, out_valid0/1=0, out_data0/1=0.
- Enqueue pairs A,B then C,D (in_two=1), no deq → count=4, out_data0=A, out_data1=B. Then deq0=deq1=1 → next cycle count=2, out_data0=C, out_data1=D.
- Fill with DEPTH=16 using single-lane groups to count=15 → in_ready=0. Single deq → count=14, in_ready=1. Group offered while in_ready=0 is dropped: count stays at 15 and content is unchanged.
- Wrap: run 40 mixed 1/2-lane enqueues and random deq patterns against a scoreboard FIFO → all payloads emerge in order, none lost or duplicated.
- deq1=1, deq0=0 with count=3 → count stays 3, out_data0 unchanged.
- flush with count=9, in_valid=1, deq0=1 in the same cycle → next cycle count=0, out_valid0=0. stall=1 with enq+deq → no change.
